// File: rtl/sample_averager.sv
// Sliding-window moving average over the last DEPTH unsigned samples.
// Ports: clk, reset (sync, active-high), data_ready/data_in (sample strobe),
//   one_k_samples (halt request), clear_err, cnt_up, avg_out, avg_valid,
//   modwait (busy), err (sticky drop flag), done (halted).
module sample_averager #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              one_k_samples,
  input  logic              clear_err,
  output logic              cnt_up,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              modwait,
  output logic              err,
  output logic              done
);

  localparam int SHIFT = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + SHIFT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUM  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] win [DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  total;
  logic              busy;
  logic              take;
  logic              drop;

  assign busy    = (state == SUM) || (state == OUT);
  assign modwait = busy;
  assign done    = (state == HALT);

  // one_k_samples has priority over a same-cycle strobe in IDLE.
  assign take = (state == IDLE) && !one_k_samples && data_ready;
  assign drop = busy && data_ready;

  always_comb begin
    total = '0;
    for (int i = 0; i < DEPTH; i++) begin
      total = total + SUM_W'(win[i]);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (one_k_samples) state_nx = HALT;
        else if (data_ready) state_nx = SUM;
      end
      SUM:  state_nx = OUT;
      OUT:  state_nx = IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Window: entry 0 is newest, entry DEPTH-1 is the oldest and falls off.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (take) begin
      win[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        win[i] <= win[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (state == SUM) begin
      sum <= total;
    end
  end

  // Upper slice of sum is the floor of sum / DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
      cnt_up    <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      cnt_up    <= 1'b0;
      if (state == OUT) begin
        avg_out   <= sum[SUM_W-1:SHIFT];
        avg_valid <= 1'b1;
        cnt_up    <= 1'b1;
      end
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
    end else if (clear_err) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_averager.sv
// Directed self-checking bench for sample_averager (DATA_W=16, DEPTH=4).
// Drives and samples on the falling clock edge.
module tb_sample_averager;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_ready;
  logic [15:0] data_in;
  logic        one_k_samples;
  logic        clear_err;
  logic        cnt_up;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        modwait;
  logic        err;
  logic        done;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int base;

  always #5 clk = ~clk;

  sample_averager #(.DATA_W(16), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_ready    (data_ready),
    .data_in       (data_in),
    .one_k_samples (one_k_samples),
    .clear_err     (clear_err),
    .cnt_up        (cnt_up),
    .avg_out       (avg_out),
    .avg_valid     (avg_valid),
    .modwait       (modwait),
    .err           (err),
    .done          (done)
  );

  always @(posedge clk) begin
    if (cnt_up || avg_valid) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // Called on a falling edge with the DUT idle; returns in the output cycle.
  task automatic send(input string tag, input logic [15:0] v,
                      input logic [15:0] e);
    data_ready = 1'b1;
    data_in    = v;
    cyc(1);
    data_ready = 1'b0;
    check({tag, "_mw1"}, modwait, 1);
    check({tag, "_av0"}, avg_valid, 0);
    cyc(1);
    check({tag, "_mw2"}, modwait, 1);
    cyc(1);
    check({tag, "_av"}, avg_valid, 1);
    check({tag, "_cu"}, cnt_up, 1);
    check({tag, "_avg"}, avg_out, e);
    check({tag, "_mw0"}, modwait, 0);
  endtask

  initial begin
    reset         = 1'b1;
    data_ready    = 1'b1;
    data_in       = 16'd5;
    one_k_samples = 1'b0;
    clear_err     = 1'b0;
    cyc(2);
    check("rst_avg", avg_out, 0);
    check("rst_av", avg_valid, 0);
    check("rst_cu", cnt_up, 0);
    check("rst_mw", modwait, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    reset      = 1'b0;
    data_ready = 1'b0;
    cyc(4);
    check("rst_nopulse", pulses, 0);
    check("rst_idle_mw", modwait, 0);

    send("single", 16'd100, 16'd25);
    cyc(1);
    check("single_1cyc", avg_valid, 0);
    check("single_cnt", pulses, 1);

    do_reset();
    send("fill1", 16'd4, 16'd1);
    send("fill2", 16'd8, 16'd3);
    send("fill3", 16'd12, 16'd6);
    send("fill4", 16'd16, 16'd10);
    send("slide", 16'd20, 16'd14);

    do_reset();
    send("tr1", 16'd1, 16'd0);
    send("tr2", 16'd1, 16'd0);
    send("tr3", 16'd1, 16'd0);
    send("tr4", 16'd0, 16'd0);

    do_reset();
    send("mx1", 16'hFFFF, 16'h3FFF);
    send("mx2", 16'hFFFF, 16'h7FFF);
    send("mx3", 16'hFFFF, 16'hBFFF);
    send("mx4", 16'hFFFF, 16'hFFFF);

    do_reset();
    cyc(1);
    base = pulses;
    data_ready = 1'b1;
    data_in    = 16'd50;
    cyc(1);
    data_in    = 16'd999;
    cyc(1);
    data_ready = 1'b0;
    check("busy_err", err, 1);
    cyc(1);
    check("busy_av", avg_valid, 1);
    check("busy_avg", avg_out, 16'd12);
    cyc(3);
    check("busy_onepulse", pulses - base, 1);
    check("busy_sticky", err, 1);

    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    check("clr_err", err, 0);

    data_ready = 1'b1;
    data_in    = 16'd7;
    cyc(1);
    data_in    = 16'd9;
    clear_err  = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    clear_err  = 1'b0;
    check("setwins", err, 1);
    cyc(2);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    check("clr_err2", err, 0);

    base = pulses;
    one_k_samples = 1'b1;
    data_ready    = 1'b1;
    data_in       = 16'd3;
    cyc(1);
    one_k_samples = 1'b0;
    check("halt_done", done, 1);
    check("halt_mw", modwait, 0);
    cyc(6);
    data_ready = 1'b0;
    cyc(2);
    check("halt_nopulse", pulses - base, 0);
    check("halt_noerr", err, 0);
    check("halt_stay", done, 1);

    do_reset();
    check("rst_undone", done, 0);
    base = pulses;
    data_ready = 1'b1;
    data_in    = 16'd40;
    cyc(1);
    data_ready = 1'b0;
    check("mid_sum", modwait, 1);
    reset = 1'b1;
    cyc(1);
    check("mid_av", avg_valid, 0);
    check("mid_cu", cnt_up, 0);
    check("mid_mw", modwait, 0);
    check("mid_avg", avg_out, 0);
    check("mid_done", done, 0);
    reset = 1'b0;
    cyc(4);
    check("mid_nopulse", pulses - base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
